// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register-file write port between the single-cycle
// path (A) and the long-latency path (B). A has priority, and an aging counter
// bounds how long B can be starved. The write port is registered.
// Optional pending-result scoreboard with hazard flags: define RF_WB_SCOREBOARD_EN.
module rf_wb_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            a_valid,
    output logic            a_ready,
    input  logic [4:0]      a_rd,
    input  logic [XLEN-1:0] a_data,
    input  logic            b_valid,
    output logic            b_ready,
    input  logic [4:0]      b_rd,
    input  logic [XLEN-1:0] b_data,
    output logic            rf_wren,
    output logic [4:0]      rf_addr,
    output logic [XLEN-1:0] rf_data,
    input  logic            alloc_valid,
    input  logic [4:0]      alloc_rd,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic            hazard_rs1,
    output logic            hazard_rs2,
    output logic            hazard_rd
);
    logic [3:0]      starve_cnt;
    logic            b_win;
    logic            fire;
    logic [4:0]      win_rd;
    logic [XLEN-1:0] win_data;

    // Same-cycle grant: A wins unless B is alone or has waited out the limit
    always_comb begin
        b_win    = b_valid && (!a_valid || starve_cnt >= 4'(STARVE_LIMIT));
        a_ready  = rst_n && a_valid && !b_win;
        b_ready  = rst_n && b_win;
        fire     = a_ready || b_ready;
        win_rd   = b_win ? b_rd : a_rd;
        win_data = b_win ? b_data : a_data;
    end

    // Registered write port; an accepted x0 write is consumed but never written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_wren <= 1'b0;
            rf_addr <= '0;
            rf_data <= '0;
        end else begin
            rf_wren <= fire && win_rd != 5'd0;
            if (fire && win_rd != 5'd0) begin
                rf_addr <= win_rd;
                rf_data <= win_data;
            end
        end
    end

    // Age B while A keeps it blocked; saturate at 15 and clear once B stops waiting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            starve_cnt <= '0;
        else
            starve_cnt <= (b_valid && !b_win) ? (starve_cnt == 4'hf ? starve_cnt : starve_cnt + 4'd1) : 4'd0;
    end

`ifdef RF_WB_SCOREBOARD_EN
    logic [31:0] pending;
    logic [31:0] set_mask;
    logic [31:0] clr_mask;

    // A new allocation outranks the completing older result for the same rd
    always_comb begin
        set_mask = (alloc_valid && alloc_rd != 5'd0) ? (32'd1 << alloc_rd) : 32'd0;
        clr_mask = b_ready ? (32'd1 << b_rd) : 32'd0;
    end

    // Pending bits for registers awaiting a B-path result; bit 0 never sets
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pending <= '0;
        else
            pending <= (pending & ~clr_mask) | set_mask;
    end

    assign hazard_rs1 = pending[rs1_addr];
    assign hazard_rs2 = pending[rs2_addr];
    assign hazard_rd  = pending[alloc_rd];
`else
    logic unused_sb;
    assign unused_sb  = ^{alloc_valid, alloc_rd, rs1_addr, rs2_addr};
    assign hazard_rs1 = 1'b0;
    assign hazard_rs2 = 1'b0;
    assign hazard_rd  = 1'b0;
`endif
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: vector table, hand sequences and random traffic against a reference model
module tb_rf_wb_arbiter;
    localparam int LIM = 4;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst_n;
    logic a_valid, b_valid, a_ready, b_ready, rf_wren;
    logic [4:0] a_rd, b_rd, rf_addr, alloc_rd, rs1_addr, rs2_addr;
    logic [XLEN-1:0] a_data, b_data, rf_data;
    logic alloc_valid, hazard_rs1, hazard_rs2, hazard_rd;

    int total = 0;
    int bad = 0;

    int m_starve;
    bit m_pend[32];
    bit m_wren;
    logic [4:0] m_addr;
    logic [XLEN-1:0] m_data;
    bit acc_a, acc_b;

    typedef struct {
        bit av; logic [4:0] ard; logic [31:0] ad;
        bit bv; logic [4:0] brd; logic [31:0] bd;
        bit ear; bit ebr; bit ew; logic [4:0] eaddr; logic [31:0] edata; bit cad;
    } vec_t;
    vec_t tbl[12];

    rf_wb_arbiter #(.STARVE_LIMIT(LIM), .XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
        .rf_wren(rf_wren), .rf_addr(rf_addr), .rf_data(rf_data),
        .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .hazard_rs1(hazard_rs1), .hazard_rs2(hazard_rs2), .hazard_rd(hazard_rd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit hz(input logic [4:0] a);
`ifdef RF_WB_SCOREBOARD_EN
        return m_pend[a];
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_starve = 0;
        m_wren = 0;
        m_addr = '0;
        m_data = '0;
        foreach (m_pend[i]) m_pend[i] = 0;
    endtask

    task automatic idle_inputs();
        a_valid = 0; a_rd = 0; a_data = 0;
        b_valid = 0; b_rd = 0; b_data = 0;
        alloc_valid = 0; alloc_rd = 0; rs1_addr = 0; rs2_addr = 0;
    endtask

    // One clock: check grants/hazards before the edge, step the model, check the write port after
    task automatic tick();
        bit bw, aw, al;
        logic [4:0] rd, ard, brd;
        logic [XLEN-1:0] d;
        #3;
        bw = b_valid && (!a_valid || m_starve >= LIM);
        aw = a_valid && !bw;
        chk("a_ready", a_ready, aw);
        chk("b_ready", b_ready, bw);
        chk("hazard_rs1", hazard_rs1, hz(rs1_addr));
        chk("hazard_rs2", hazard_rs2, hz(rs2_addr));
        chk("hazard_rd", hazard_rd, hz(alloc_rd));
        acc_a = aw;
        acc_b = bw;
        rd = bw ? b_rd : a_rd;
        d = bw ? b_data : a_data;
        brd = b_rd;
        al = alloc_valid;
        ard = alloc_rd;
        @(posedge clk);
        #1;
        m_wren = (aw || bw) && rd != 0;
        if (m_wren) begin
            m_addr = rd;
            m_data = d;
        end
        m_starve = (b_valid && !bw) ? (m_starve < 15 ? m_starve + 1 : 15) : 0;
        if (bw) m_pend[brd] = 0;
        if (al && ard != 0) m_pend[ard] = 1;
        chk("rf_wren", rf_wren, m_wren);
        if (m_wren) begin
            chk("rf_addr", rf_addr, m_addr);
            chk("rf_data", rf_data, m_data);
        end
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        model_reset();
        tbl[0]  = '{0, 0, 0,            0, 0, 0,            0, 0, 0, 0, 0,            1};
        tbl[1]  = '{1, 5, 32'hDEADBEEF, 0, 0, 0,            1, 0, 1, 5, 32'hDEADBEEF, 1};
        tbl[2]  = '{0, 0, 0,            1, 9, 32'h12345678, 0, 1, 1, 9, 32'h12345678, 1};
        tbl[3]  = '{0, 0, 0,            1, 0, 32'h0000AAAA, 0, 1, 0, 0, 0,            0};
        tbl[4]  = '{0, 0, 0,            0, 0, 0,            0, 0, 0, 0, 0,            0};
        for (int i = 5; i <= 8; i++)
            tbl[i] = '{1, 1, 32'h11, 1, 2, 32'h22, 1, 0, 1, 1, 32'h11, 1};
        tbl[9]  = '{1, 1, 32'h11, 1, 2, 32'h22, 0, 1, 1, 2, 32'h22, 1};
        tbl[10] = '{1, 1, 32'h11, 0, 0, 0,      1, 0, 1, 1, 32'h11, 1};
        tbl[11] = '{0, 0, 0,      0, 0, 0,      0, 0, 0, 1, 32'h11, 1};

        repeat (2) @(posedge clk);
        #1;
        a_valid = 1; b_valid = 1;
        #1;
        chk("rst_a_ready", a_ready, 0);
        chk("rst_b_ready", b_ready, 0);
        chk("rst_wren", rf_wren, 0);
        chk("rst_addr", rf_addr, 0);
        chk("rst_data", rf_data, 0);
        idle_inputs();
        rst_n = 1;
        #1;
        chk("idle_a_ready", a_ready, 0);
        chk("idle_b_ready", b_ready, 0);
        chk("idle_hz", {hazard_rs1, hazard_rs2, hazard_rd}, 0);

        for (int i = 0; i < 12; i++) begin
            a_valid = tbl[i].av; a_rd = tbl[i].ard; a_data = tbl[i].ad;
            b_valid = tbl[i].bv; b_rd = tbl[i].brd; b_data = tbl[i].bd;
            tick();
            chk($sformatf("tbl%0d_a_ready", i), acc_a, tbl[i].ear);
            chk($sformatf("tbl%0d_b_ready", i), acc_b, tbl[i].ebr);
            chk($sformatf("tbl%0d_wren", i), rf_wren, tbl[i].ew);
            if (tbl[i].cad) begin
                chk($sformatf("tbl%0d_addr", i), rf_addr, tbl[i].eaddr);
                chk($sformatf("tbl%0d_data", i), rf_data, tbl[i].edata);
            end
        end
        idle_inputs();

`ifdef RF_WB_SCOREBOARD_EN
        alloc_valid = 1; alloc_rd = 7; rs1_addr = 7;
        tick();
        #1;
        chk("sb_set_rs1", hazard_rs1, 1);
        chk("sb_set_rd", hazard_rd, 1);
        alloc_valid = 0;
        b_valid = 1; b_rd = 7; b_data = 32'h77;
        tick();
        b_valid = 0;
        #1;
        chk("sb_clear_rs1", hazard_rs1, 0);
        alloc_valid = 1;
        tick();
        b_valid = 1;
        tick();
        alloc_valid = 0; b_valid = 0;
        #1;
        chk("sb_set_wins", hazard_rs1, 1);
        b_valid = 1;
        tick();
        b_valid = 0;
        #1;
        chk("sb_final_clear", hazard_rs1, 0);
`else
        alloc_valid = 1; alloc_rd = 7; rs1_addr = 7; rs2_addr = 7;
        tick();
        alloc_valid = 0;
        #1;
        chk("nosb_hz", {hazard_rs1, hazard_rs2, hazard_rd}, 0);
`endif
        idle_inputs();

        a_valid = 1; a_rd = 3; a_data = 32'h33;
        b_valid = 1; b_rd = 4; b_data = 32'h44;
        alloc_valid = 1; alloc_rd = 7; rs1_addr = 7;
        repeat (3) tick();
        alloc_valid = 0;
        chk("pre_rst_wren", rf_wren, 1);
        #2;
        rst_n = 0;
        #1;
        chk("async_wren", rf_wren, 0);
        chk("async_addr", rf_addr, 0);
        chk("async_data", rf_data, 0);
        chk("async_hz", {hazard_rs1, hazard_rs2, hazard_rd}, 0);
        chk("async_ready", {a_ready, b_ready}, 0);
        model_reset();
        rst_n = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("age_after_rst%0d", i), acc_b, i == 4);
        end
        idle_inputs();

        for (int n = 0; n < 400; n++) begin
            if (!(a_valid && !acc_a)) begin
                a_valid = $urandom_range(0, 99) < 60;
                a_rd = 5'($urandom_range(0, 31));
                a_data = $urandom;
            end
            if (!(b_valid && !acc_b)) begin
                b_valid = $urandom_range(0, 99) < 50;
                b_rd = 5'($urandom_range(0, 7));
                b_data = $urandom;
            end
            alloc_valid = $urandom_range(0, 99) < 30;
            alloc_rd = 5'($urandom_range(0, 7));
            rs1_addr = 5'($urandom_range(0, 7));
            rs2_addr = 5'($urandom_range(0, 7));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
